// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   Resynchronises the ripple counter's NUM bus, accepts a value only after
//   two identical consecutive samples, and pushes each new distinct value into
//   a first-word-fall-through FIFO of 2**ADDR_W 4-bit entries.
//   Optional feature macro: COUNT_FIFO_DROP_COUNT_EN adds a saturating DROPS
//   counter output. Without it the DROPS port does not exist.
//
//   Read handshake: DOUT is the head entry whenever EMPTY=0 (EMPTY acts as the
//   inverse of valid). A pop happens at the rising edge where RD_EN=1 and
//   EMPTY=0; RD_EN while EMPTY=1 is ignored without error.
module count_capture_fifo #(
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              CLEAR_BAR,
    input  logic [3:0]        NUM,
    input  logic              RD_EN,
    output logic [3:0]        DOUT,
    output logic              EMPTY,
    output logic              FULL,
    output logic [ADDR_W:0]   LEVEL,
    output logic              OVERFLOW
`ifdef COUNT_FIFO_DROP_COUNT_EN
    ,
    output logic [3:0]        DROPS
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      prev_q, prev_d;
    logic [3:0]      last_cap_q, last_cap_d;
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [3:0]      mem_q [DEPTH];
    logic [3:0]      mem_d [DEPTH];
    logic            overflow_q, overflow_d;
`ifdef COUNT_FIFO_DROP_COUNT_EN
    logic [3:0]      drops_q, drops_d;
`endif

    logic stable;
    logic capture;
    logic pop;
    logic push;
    logic drop;
    logic empty;
    logic full;

    // Status derived from the registered pointers and the sampling chain
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
        stable  = (sync2_q == prev_q);
        capture = stable && (sync2_q != last_cap_q);
        pop     = RD_EN && !empty;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    // Next-state: sampling chain, capture tracking, FIFO storage and pointers
    always_comb begin
        sync1_d    = NUM;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        last_cap_d = last_cap_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_d      = mem_q;
        overflow_d = overflow_q;
        // A captured value is consumed even when it is dropped, so it is never retried.
        if (capture) begin
            last_cap_d = sync2_q;
        end
        if (push) begin
            mem_d[wptr_q[ADDR_W-1:0]] = sync2_q;
            wptr_d = wptr_q + (ADDR_W+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (ADDR_W+1)'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

`ifdef COUNT_FIFO_DROP_COUNT_EN
    // Saturating count of discarded captures
    always_comb begin
        drops_d = drops_q;
        if (drop && (drops_q != 4'hF)) begin
            drops_d = drops_q + 4'd1;
        end
    end

    // Drop counter register, cleared only by CLEAR_BAR
    always_ff @(posedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) begin
            drops_q <= 4'h0;
        end else begin
            drops_q <= drops_d;
        end
    end

    assign DROPS = drops_q;
`endif

    // State registers; CLEAR_BAR wipes everything immediately
    always_ff @(posedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) begin
            sync1_q    <= 4'h0;
            sync2_q    <= 4'h0;
            prev_q     <= 4'h0;
            last_cap_q <= 4'h0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            last_cap_q <= last_cap_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    // Output mapping; DOUT reads as zero while empty
    always_comb begin
        EMPTY    = empty;
        FULL     = full;
        LEVEL    = wptr_q - rptr_q;
        OVERFLOW = overflow_q;
        DOUT     = empty ? 4'h0 : mem_q[rptr_q[ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Testbench for count_capture_fifo (DEPTH = 8). Honours COUNT_FIFO_DROP_COUNT_EN.
module tb_count_capture_fifo;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic            clk;
    logic            clear_bar;
    logic [3:0]      num;
    logic            rd_en;
    logic [3:0]      dout;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] level;
    logic            overflow;
`ifdef COUNT_FIFO_DROP_COUNT_EN
    logic [3:0]      drops;
`endif

    count_capture_fifo #(.ADDR_W(ADDR_W)) dut (
        .CLK       (clk),
        .CLEAR_BAR (clear_bar),
        .NUM       (num),
        .RD_EN     (rd_en),
        .DOUT      (dout),
        .EMPTY     (empty),
        .FULL      (full),
        .LEVEL     (level),
        .OVERFLOW  (overflow)
`ifdef COUNT_FIFO_DROP_COUNT_EN
        ,
        .DROPS     (drops)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    logic [3:0] exp_q[$];
    logic [3:0] m_last;
    logic       m_ovf;
    int         m_drops;
    int         checks;
    int         failures;

    // Advance n rising edges, leaving time 1 unit after the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a value on NUM long enough for it to be captured and written
    task automatic present(input logic [3:0] v);
        num = v;
        tick(4);
        if (v != m_last) begin
            m_last = v;
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(v);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 15) m_drops++;
            end
        end
    endtask

    // Pop one entry, comparing DOUT against the scoreboard head
    task automatic pop_one(input string tag);
        logic [3:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty on pop, dout=%h", tag, dout);
        end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
                failures++;
                $display("FAIL %s: dout=%h expected=%h", tag, dout, e);
            end
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_last  = 4'h0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic test_reset();
        clear_bar = 1'b0;
        num       = 4'h0;
        rd_en     = 1'b0;
        model_clear();
        tick(2);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0 || dout !== 4'h0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: empty=%b full=%b level=%0d dout=%h ovf=%b expected 1 0 0 0 0",
                     empty, full, level, dout, overflow);
        end
`ifdef COUNT_FIFO_DROP_COUNT_EN
        checks++;
        if (drops !== 4'h0) begin
            failures++;
            $display("FAIL reset_drops: drops=%h expected=0", drops);
        end
`endif
        clear_bar = 1'b1;
        tick(4);
        checks++;
        if (empty !== 1'b1 || level !== 4'd0) begin
            failures++;
            $display("FAIL zero_not_captured: empty=%b level=%0d expected empty=1 level=0", empty, level);
        end
    endtask

    task automatic test_first_capture();
        num = 4'h1;
        tick(3);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL capture_latency_early: empty=%b expected=1 after edge k+2", empty);
        end
        tick(1);
        m_last = 4'h1;
        exp_q.push_back(4'h1);
        checks++;
        if (empty !== 1'b0 || dout !== 4'h1 || level !== 4'd1) begin
            failures++;
            $display("FAIL first_capture: empty=%b dout=%h level=%0d expected 0 1 1", empty, dout, level);
        end
    endtask

    task automatic test_glitch();
        num = 4'h3;
        tick(1);
        num = 4'h2;
        tick(5);
        m_last = 4'h2;
        exp_q.push_back(4'h2);
        checks++;
        if (level !== 4'(exp_q.size())) begin
            failures++;
            $display("FAIL glitch_level: level=%0d expected=%0d", level, exp_q.size());
        end
        pop_one("glitch_pop_a");
        pop_one("glitch_pop_b");
        checks++;
        if (empty !== 1'b1 || dout !== 4'h0) begin
            failures++;
            $display("FAIL glitch_drained: empty=%b dout=%h expected 1 0", empty, dout);
        end
    endtask

    task automatic test_fill_overflow_drain();
        for (int i = 1; i <= 8; i++) present(4'(i));
        checks++;
        if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill: full=%b level=%0d ovf=%b expected 1 8 0", full, level, overflow);
        end
        present(4'h9);
        checks++;
        if (overflow !== m_ovf || level !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow: ovf=%b level=%0d full=%b expected ovf=%b level=8 full=1",
                     overflow, level, full, m_ovf);
        end
`ifdef COUNT_FIFO_DROP_COUNT_EN
        checks++;
        if (drops !== 4'(m_drops)) begin
            failures++;
            $display("FAIL drops_count: drops=%0d expected=%0d", drops, m_drops);
        end
`endif
        for (int i = 0; i < 8; i++) pop_one("drain_pop");
        checks++;
        if (empty !== 1'b1 || dout !== 4'h0 || level !== 4'd0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b dout=%h level=%0d expected 1 0 0", empty, dout, level);
        end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] e;
        for (int i = 1; i <= 8; i++) present(4'(i));
        num = 4'hA;
        tick(3);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || full !== 1'b1) begin
            failures++;
            $display("FAIL pp_head: dout=%h full=%b expected dout=%h full=1", dout, full, e);
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        m_last = 4'hA;
        exp_q.push_back(4'hA);
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== m_ovf) begin
            failures++;
            $display("FAIL pp_level: level=%0d full=%b ovf=%b expected 8 1 %b", level, full, overflow, m_ovf);
        end
`ifdef COUNT_FIFO_DROP_COUNT_EN
        checks++;
        if (drops !== 4'(m_drops)) begin
            failures++;
            $display("FAIL pp_drops: drops=%0d expected=%0d", drops, m_drops);
        end
`endif
        for (int i = 0; i < 8; i++) pop_one("pp_drain_pop");
    endtask

    task automatic test_underflow_wrap();
        logic [3:0] v;
        rd_en = 1'b1;
        tick(2);
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || level !== 4'd0 || dout !== 4'h0 || overflow !== m_ovf) begin
            failures++;
            $display("FAIL underflow: empty=%b level=%0d dout=%h ovf=%b expected 1 0 0 %b",
                     empty, level, dout, overflow, m_ovf);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 2; j++) begin
                v = 4'($urandom_range(0, 15));
                while (v == m_last) v = 4'($urandom_range(0, 15));
                present(v);
                checks++;
                if (level > 4'd8 || level !== 4'(exp_q.size())) begin
                    failures++;
                    $display("FAIL wrap_level: level=%0d expected=%0d", level, exp_q.size());
                end
            end
            pop_one("wrap_pop");
            pop_one("wrap_pop");
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 11; i <= 15; i++) present(4'(i));
        checks++;
        if (level !== 4'd5 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: level=%0d ovf=%b expected 5 1", level, overflow);
        end
        #2;
        clear_bar = 1'b0;
        #1;
        model_clear();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0 || dout !== 4'h0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: empty=%b full=%b level=%0d dout=%h ovf=%b expected 1 0 0 0 0",
                     empty, full, level, dout, overflow);
        end
`ifdef COUNT_FIFO_DROP_COUNT_EN
        checks++;
        if (drops !== 4'h0) begin
            failures++;
            $display("FAIL async_reset_drops: drops=%h expected=0", drops);
        end
`endif
        num = 4'h0;
        tick(2);
        clear_bar = 1'b1;
        tick(2);
        present(4'h7);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_level: level=%0d expected=1", level);
        end
        pop_one("post_reset_pop");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_capture();
        test_glitch();
        test_fill_overflow_drain();
        test_push_pop_full();
        test_underflow_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
